// File: rtl/maze_countdown_timer_if.sv
// Control and status bundle for maze_countdown_timer.
// BCD display fields exist only when MAZE_TIMER_BCD_EN is defined.
interface maze_countdown_timer_if;
   logic       load;
   logic [6:0] load_mins;
   logic [5:0] load_secs;
   logic       start;
   logic       pause;
   logic       add_en;
   logic [5:0] add_secs;
   logic       running;
   logic       tick;
   logic       warning;
   logic       timer_end;
   logic [6:0] min_out;
   logic [5:0] sec_out;
`ifdef MAZE_TIMER_BCD_EN
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
`endif

   modport slave (
      input  load, load_mins, load_secs, start, pause, add_en, add_secs,
`ifdef MAZE_TIMER_BCD_EN
      output min_bcd, sec_bcd,
`endif
      output running, tick, warning, timer_end, min_out, sec_out
   );

   modport master (
      output load, load_mins, load_secs, start, pause, add_en, add_secs,
`ifdef MAZE_TIMER_BCD_EN
      input  min_bcd, sec_bcd,
`endif
      input  running, tick, warning, timer_end, min_out, sec_out
   );
endinterface

// File: rtl/maze_countdown_timer.sv
// Minutes/seconds countdown game timer with pause, bonus add and sticky expiry.
// Optional packed-BCD display outputs are enabled by MAZE_TIMER_BCD_EN.
module maze_countdown_timer #(
   parameter int CLK_F     = 50000000,
   parameter int DEF_MINS  = 1,
   parameter int DEF_SECS  = 0,
   parameter int MAX_MINS  = 99,
   parameter int WARN_SECS = 10
) (
   input logic              clock,
   input logic              reset,
   maze_countdown_timer_if.slave bus
);
   localparam int          PW      = $clog2(CLK_F);
   localparam logic [PW-1:0] TERM  = PW'(CLK_F - 1);
   localparam logic [12:0] MAX_TOT = 13'(MAX_MINS * 60 + 59);

   typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

   state_t        state_reg, state_next;
   logic [PW-1:0] presc_reg, presc_next;
   logic [6:0]    min_reg, min_next;
   logic [5:0]    sec_reg, sec_next;
   logic          tick_reg, timer_end_reg;

   logic [12:0]   tot_reg, dec_tot, sum_raw, sum_sat;
   logic          tick_fire, add_ok;
   logic [6:0]    load_min_clamped;
   logic [5:0]    load_sec_clamped;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Time is handled as a single seconds total so tick and bonus combine in one step.
   always_comb begin
      tot_reg   = 13'(min_reg) * 13'd60 + 13'(sec_reg);
      tick_fire = (state_reg == RUN) && !bus.load && !bus.pause &&
                  (presc_reg == TERM) && (tot_reg != 13'd0);
      add_ok    = bus.add_en && !bus.load && (state_reg != EXPIRED);
      dec_tot   = tick_fire ? (tot_reg - 13'd1) : tot_reg;
      sum_raw   = add_ok ? (dec_tot + 13'(bus.add_secs)) : dec_tot;
      sum_sat   = (sum_raw > MAX_TOT) ? MAX_TOT : sum_raw;
      load_min_clamped = (bus.load_mins > 7'(MAX_MINS)) ? 7'(MAX_MINS) : bus.load_mins;
      load_sec_clamped = (bus.load_secs > 6'd59) ? 6'd59 : bus.load_secs;
   end

   always_comb begin
      state_next = state_reg;
      if (bus.load) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (bus.start) state_next = (sum_sat == 13'd0) ? EXPIRED : RUN;
            RUN: begin
               if (bus.pause)                          state_next = PAUSED;
               else if (tick_fire && sum_sat == 13'd0) state_next = EXPIRED;
            end
            PAUSED:  if (bus.start) state_next = RUN;
            default: state_next = EXPIRED;
         endcase
      end
   end

   always_comb begin
      bus.running = (state_reg == RUN);
      bus.warning = (state_reg != EXPIRED) && (tot_reg <= 13'(WARN_SECS)) &&
                    (tot_reg != 13'd0);
   end

   always_comb begin
      presc_next = presc_reg;
      if (bus.load || state_reg == IDLE || state_reg == EXPIRED) presc_next = '0;
      else if (state_reg == RUN && !bus.pause) presc_next = tick_fire ? '0 : presc_reg + 1'b1;
      if (bus.load) begin
         min_next = load_min_clamped;
         sec_next = load_sec_clamped;
      end else begin
         min_next = 7'(sum_sat / 13'd60);
         sec_next = 6'(sum_sat % 13'd60);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc_reg     <= '0;
         min_reg       <= 7'(DEF_MINS);
         sec_reg       <= 6'(DEF_SECS);
         tick_reg      <= 1'b0;
         timer_end_reg <= 1'b0;
      end else begin
         presc_reg     <= presc_next;
         min_reg       <= min_next;
         sec_reg       <= sec_next;
         tick_reg      <= tick_fire;
         timer_end_reg <= (state_next == EXPIRED);
      end
   end

   assign bus.tick      = tick_reg;
   assign bus.timer_end = timer_end_reg;
   assign bus.min_out   = min_reg;
   assign bus.sec_out   = sec_reg;

`ifdef MAZE_TIMER_BCD_EN
   function automatic logic [7:0] to_bcd(input logic [6:0] v);
      logic [6:0] s;
      s = (v > 7'd99) ? 7'd99 : v;
      return {4'(s / 7'd10), 4'(s % 7'd10)};
   endfunction

   logic [7:0] min_bcd_reg, sec_bcd_reg;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         min_bcd_reg <= to_bcd(7'(DEF_MINS));
         sec_bcd_reg <= to_bcd(7'(DEF_SECS));
      end else begin
         min_bcd_reg <= to_bcd(min_next);
         sec_bcd_reg <= to_bcd({1'b0, sec_next});
      end
   end

   assign bus.min_bcd = min_bcd_reg;
   assign bus.sec_bcd = sec_bcd_reg;
`endif
endmodule

// File: tb/tb_maze_countdown_timer.sv
// Directed bench for maze_countdown_timer with CLK_F=4 and a 00:03 reset value.
module tb_maze_countdown_timer;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   total  = 0;
   int   passed = 0;

   maze_countdown_timer_if bus();

   maze_countdown_timer #(
      .CLK_F(4), .DEF_MINS(0), .DEF_SECS(3), .MAX_MINS(99), .WARN_SECS(10)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_load(input logic [6:0] m, input logic [5:0] s);
      bus.load = 1'b1; bus.load_mins = m; bus.load_secs = s;
      step();
      bus.load = 1'b0;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   initial begin
      logic saw_tick;
      bus.load = 0; bus.load_mins = 0; bus.load_secs = 0;
      bus.start = 0; bus.pause = 0; bus.add_en = 0; bus.add_secs = 0;

      // Reset state
      #12;
      check("rst_min", 16'(bus.min_out), 16'd0);
      check("rst_sec", 16'(bus.sec_out), 16'd3);
      check("rst_tick", 16'(bus.tick), 16'd0);
      check("rst_running", 16'(bus.running), 16'd0);
      check("rst_end", 16'(bus.timer_end), 16'd0);
      check("rst_warning", 16'(bus.warning), 16'd1);
`ifdef MAZE_TIMER_BCD_EN
      check("rst_sec_bcd", 16'(bus.sec_bcd), 16'h03);
`endif
      @(negedge clock);
      reset = 1'b1;
      step();

      // Count 00:03 down to expiry
      do_start();
      check("run_running", 16'(bus.running), 16'd1);
      for (int k = 1; k <= 3; k++) begin
         repeat (3) step();
         check("pre_tick", 16'(bus.tick), 16'd0);
         step();
         check("tick", 16'(bus.tick), 16'd1);
         check("tick_sec", 16'(bus.sec_out), 16'(3 - k));
      end
      check("exp_end", 16'(bus.timer_end), 16'd1);
      check("exp_running", 16'(bus.running), 16'd0);
      check("exp_warning", 16'(bus.warning), 16'd0);
      step();
      check("exp_tick_clr", 16'(bus.tick), 16'd0);
      check("exp_end_hold", 16'(bus.timer_end), 16'd1);

      // 01:00 borrow and warning threshold
      do_load(7'd1, 6'd0);
      check("load_end_clr", 16'(bus.timer_end), 16'd0);
      check("load_min", 16'(bus.min_out), 16'd1);
      do_start();
      repeat (4) step();
      check("borrow_min", 16'(bus.min_out), 16'd0);
      check("borrow_sec", 16'(bus.sec_out), 16'd59);
      check("borrow_warn", 16'(bus.warning), 16'd0);
      repeat (48 * 4) step();
      check("sec11", 16'(bus.sec_out), 16'd11);
      check("sec11_warn", 16'(bus.warning), 16'd0);
      repeat (4) step();
      check("sec10", 16'(bus.sec_out), 16'd10);
      check("sec10_warn", 16'(bus.warning), 16'd1);

      // Pause holds the prescaler
      do_load(7'd0, 6'd30);
      do_start();
      repeat (2) step();
      bus.pause = 1'b1; step(); bus.pause = 1'b0;
      check("paused_running", 16'(bus.running), 16'd0);
      saw_tick = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.tick) saw_tick = 1'b1;
      end
      check("paused_no_tick", 16'(saw_tick), 16'd0);
      check("paused_sec", 16'(bus.sec_out), 16'd30);
      do_start();
      step();
      check("resume_wait", 16'(bus.tick), 16'd0);
      step();
      check("resume_tick", 16'(bus.tick), 16'd1);
      check("resume_sec", 16'(bus.sec_out), 16'd29);

      // Add saturation, load clamp, add ignored when expired
      do_load(7'd99, 6'd50);
      bus.add_en = 1'b1; bus.add_secs = 6'd30; step(); bus.add_en = 1'b0;
      check("sat_min", 16'(bus.min_out), 16'd99);
      check("sat_sec", 16'(bus.sec_out), 16'd59);
      do_load(7'd127, 6'd63);
      check("clamp_min", 16'(bus.min_out), 16'd99);
      check("clamp_sec", 16'(bus.sec_out), 16'd59);
      do_load(7'd0, 6'd0);
      do_start();
      check("zero_start_end", 16'(bus.timer_end), 16'd1);
      bus.add_en = 1'b1; bus.add_secs = 6'd5; step(); bus.add_en = 1'b0;
      check("exp_add_sec", 16'(bus.sec_out), 16'd0);
      check("exp_add_end", 16'(bus.timer_end), 16'd1);

      // Add coinciding with the final tick
      do_load(7'd0, 6'd1);
      do_start();
      repeat (3) step();
      bus.add_en = 1'b1; bus.add_secs = 6'd5; step(); bus.add_en = 1'b0;
      check("coinc_tick", 16'(bus.tick), 16'd1);
      check("coinc_sec", 16'(bus.sec_out), 16'd5);
      check("coinc_end", 16'(bus.timer_end), 16'd0);
      check("coinc_running", 16'(bus.running), 16'd1);
      bus.add_en = 1'b1; bus.add_secs = 6'd0; step(); bus.add_en = 1'b0;
      check("add_zero_sec", 16'(bus.sec_out), 16'd5);

      // Load beats start in the same cycle
      bus.start = 1'b1;
      do_load(7'd2, 6'd15);
      bus.start = 1'b0;
      check("ld_st_running", 16'(bus.running), 16'd0);
      check("ld_st_min", 16'(bus.min_out), 16'd2);
      check("ld_st_sec", 16'(bus.sec_out), 16'd15);
      step();
      check("ld_st_idle", 16'(bus.running), 16'd0);

      // Asynchronous reset mid-run
      do_start();
      repeat (6) step();
      reset = 1'b0;
      #1;
      check("arst_min", 16'(bus.min_out), 16'd0);
      check("arst_sec", 16'(bus.sec_out), 16'd3);
      check("arst_end", 16'(bus.timer_end), 16'd0);
      check("arst_running", 16'(bus.running), 16'd0);
      check("arst_tick", 16'(bus.tick), 16'd0);
      reset = 1'b1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/maze_countdown_timer.md
Name: maze_countdown_timer

Overview:
- Parameterised countdown game timer: minutes/seconds display value, runtime load, start/pause control and bonus-time add.
- Adds a warning flag, a 1-second tick pulse and an explicit run-state machine.
- Feeds the seven-segment display driver and the game-control FSM.
- Expiry is a sticky flag cleared only by load or reset.

Parameters:
- CLK_F, 50000000, input clock frequency in Hz; prescaler terminal count is CLK_F-1; must be >= 2.
- DEF_MINS, 1, minutes value after reset; must be <= MAX_MINS.
- DEF_SECS, 0, seconds value after reset; 0..59.
- MAX_MINS, 99, minutes ceiling for load and add saturation; <= 127.
- WARN_SECS, 10, warning asserted when total remaining seconds <= WARN_SECS and > 0.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- load  in  1  one-cycle strobe: copy load_mins/load_secs, go to IDLE
- load_mins  in  7  minutes to load; clamped to MAX_MINS
- load_secs  in  6  seconds to load; clamped to 59
- start  in  1  one-cycle strobe: begin or resume counting
- pause  in  1  one-cycle strobe: freeze counting
- add_en  in  1  one-cycle strobe: add add_secs to remaining time
- add_secs  in  6  bonus seconds, 0..63
- running  out  1  high in RUN
- tick  out  1  one-cycle pulse on each 1-second decrement
- warning  out  1  low-time flag
- timer_end  out  1  sticky expiry flag
- min_out  out  7  remaining minutes
- sec_out  out  6  remaining seconds, 0..59

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, prescaler=0, min_out=DEF_MINS, sec_out=DEF_SECS.
  - tick=0, running=0, timer_end=0.
  - warning is recomputed from the reset value.
- All outputs are registered except warning and running, which are decoded combinationally from registers.
- States:
  - IDLE: prescaler held at 0, time held.
  - RUN: prescaler increments every cycle.
  - PAUSED: prescaler and time frozen, prescaler not cleared.
  - EXPIRED: time = 00:00, timer_end=1.
- Transitions:
  - IDLE --start--> RUN, but go to EXPIRED if time is 00:00.
  - RUN --pause--> PAUSED.
  - PAUSED --start--> RUN, resuming the prescaler from its held value.
  - RUN, decrement reaching 00:00 --> EXPIRED.
  - Any state --load--> IDLE, prescaler cleared, timer_end cleared.
- Strobe priority within a cycle: load > pause > start. add_en is independent and applies alongside start/pause.
- Tick: in RUN, when prescaler==CLK_F-1:
  - prescaler returns to 0; tick=1 for exactly the next cycle.
  - Time decrements by one second: sec 0 with min>0 becomes sec 59, min-1.
  - First tick occurs CLK_F cycles after start from IDLE.
- Expiry: on the clock edge where the time registers become 00:00, state=EXPIRED and timer_end=1 in the same cycle. tick is also asserted for that cycle.
- Add:
  - Total = min*60 + sec + add_secs, converted back to min/sec.
  - Saturates at MAX_MINS:59.
  - Accepted in IDLE, RUN and PAUSED; ignored in EXPIRED.
  - If a tick and add_en coincide, result = old - 1 + add_secs, saturating.
  - add_secs=0 leaves the time unchanged.
- Load: values are clamped, not wrapped (load_secs=63 gives 59). Load during RUN aborts the current second.
- warning = (state != EXPIRED) && (remaining total <= WARN_SECS) && (remaining total > 0). With WARN_SECS=0, warning is never asserted.
- Arithmetic: the total-seconds path needs at least 13 bits (99*60+59+63 = 6062). Minutes never underflow below 0.

Optional Feature:
- Macro: MAZE_TIMER_BCD_EN.
- When defined:
  - Adds outputs min_bcd[7:0] and sec_bcd[7:0]: two packed BCD digits, tens in [7:4].
  - They are registered and update on the same edge as min_out/sec_out.
  - Reset values are the BCD of DEF_MINS and DEF_SECS.
  - min_bcd saturates at 99 if MAX_MINS > 99.
- When not defined: these ports do not exist and no BCD logic is synthesised.
- Core behaviour is identical either way.

Test Plan:
- Use CLK_F=4, DEF_MINS=0, DEF_SECS=3. Reset, start -> tick after 4 cycles each; sec_out goes 2, 1, 0; timer_end=1 and tick=1 on the 3rd tick edge; state EXPIRED; warning 0 after expiry.
- load min=1 sec=0, start, 1 tick -> min_out=0, sec_out=59; warning=0. Continue to sec=10 -> warning=1.
- RUN, pause after 2 prescaler cycles, hold 20 cycles -> no tick, time unchanged. start -> next tick exactly 2 cycles later.
- min=99 sec=50, add_en with add_secs=30 -> saturates at 99:59. Then add_en at 00:00 EXPIRED -> ignored, timer_end stays 1.
- add_en with add_secs=5 on the same cycle as a tick at 00:01 -> result 00:05, no expiry. Separately: load and start in the same cycle -> IDLE, loaded value, running=0.
- Assert reset mid-RUN -> outputs return immediately to DEF_MINS:DEF_SECS with timer_end=0, without waiting for a clock edge.
